// File: rtl/benes_pkg.sv
// -----------------------------------------------------------------------------
// benes_pkg
// Shared definitions for the 4-port Benes reconfiguration controller:
//   - controller state encoding
//   - error codes reported on err_code
//   - identity permutation / identity switch state
//   - port field widths
// No ports (package).
// -----------------------------------------------------------------------------
package benes_pkg;

  localparam int PERM_W  = 8;  // four 2-bit destination fields
  localparam int FIELD_W = 2;
  localparam int SW_W    = 6;  // six 2x2 switches
  localparam int ERR_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    DRAIN  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_PERM    = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [PERM_W-1:0] PERM_IDENTITY = 8'h1B;
  localparam logic [SW_W-1:0]   SW_IDENTITY   = 6'b111111;

endpackage

// File: rtl/benes_4_cfg_ctrl_if.sv
// -----------------------------------------------------------------------------
// benes_4_cfg_ctrl_if
// Request handshake plus fabric control/status between the fabric-management
// logic (master) and the reconfiguration controller (slave).
//   req_valid/req_perm/req_ready : permutation request handshake
//   net_busy                     : fabric has traffic in flight
//   quiesce                      : upstream must stop injecting traffic
//   sw_state/cfg_live            : switch settings and their validity
//   done/err/err_code            : completion pulses and sticky error code
// -----------------------------------------------------------------------------
interface benes_4_cfg_ctrl_if;
  import benes_pkg::*;

  logic              req_valid;
  logic [PERM_W-1:0] req_perm;
  logic              req_ready;
  logic              net_busy;
  logic              quiesce;
  logic [SW_W-1:0]   sw_state;
  logic              cfg_live;
  logic              done;
  logic              err;
  logic [ERR_W-1:0]  err_code;

  modport master (
    output req_valid, req_perm, net_busy,
    input  req_ready, quiesce, sw_state, cfg_live, done, err, err_code
  );

  modport slave (
    input  req_valid, req_perm, net_busy,
    output req_ready, quiesce, sw_state, cfg_live, done, err, err_code
  );

endinterface

// File: rtl/benes_4_route_lut.sv
// -----------------------------------------------------------------------------
// benes_4_route_lut
// Combinational permutation -> switch-state lookup for the 4-port Benes fabric.
// Field in<i> of the permutation names the output port that input i reaches.
// Topology: first-stage switch j takes inputs 2j/2j+1, its output k feeds
// middle switch k (port j); middle switch j output k feeds last switch k
// (port j); last switch k drives outputs 2k/2k+1. A bit of 1 is "straight".
//   i_perm     : {in0,in1,in2,in3}, in0 in [7:6]
//   o_sw_state : {s0_0,s0_1,s0_2,s1_0,s1_1,s1_2} (switch_stage), 0 if invalid
//   o_perm_ok  : the four fields are pairwise distinct
// -----------------------------------------------------------------------------
module benes_4_route_lut
  import benes_pkg::*;
(
  input  logic [PERM_W-1:0] i_perm,
  output logic [SW_W-1:0]   o_sw_state,
  output logic              o_perm_ok
);

  logic [FIELD_W-1:0] w_d0, w_d1, w_d2, w_d3;
  logic               w_split;     // in0 and in1 land on different last switches
  logic               w_first1;    // first-stage switch 1
  logic               w_last_own;  // last switch carrying in0
  logic               w_last_oth;  // the other last switch
  logic [SW_W-1:0]    w_sw;

  assign w_d0 = i_perm[7:6];
  assign w_d1 = i_perm[5:4];
  assign w_d2 = i_perm[3:2];
  assign w_d3 = i_perm[1:0];

  assign o_perm_ok = (w_d0 != w_d1) && (w_d0 != w_d2) && (w_d0 != w_d3) &&
                     (w_d1 != w_d2) && (w_d1 != w_d3) && (w_d2 != w_d3);

  // Looping algorithm with first-stage switch 0 pinned straight. When in0/in1
  // share a last switch, the loop closes early and first-stage switch 1 is free;
  // it is then held straight so identity-like halves stay all-ones.
  assign w_split    = (w_d0[1] != w_d1[1]);
  assign w_first1   = w_split ? (w_d2 == (w_d1 ^ 2'b01)) : 1'b1;
  assign w_last_own = ~w_d0[0];
  assign w_last_oth = w_split ? w_d1[0] : ~w_d2[0];

  assign w_sw = {1'b1,                                   // s0_0
                 ~w_d0[1],                               // s0_1
                 w_d0[1] ? w_last_oth : w_last_own,      // s0_2
                 w_first1,                               // s1_0
                 ~w_d1[1],                               // s1_1
                 w_d0[1] ? w_last_own : w_last_oth};     // s1_2

  assign o_sw_state = o_perm_ok ? w_sw : '0;

endmodule

// File: rtl/benes_4_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// benes_4_cfg_ctrl
// Reconfiguration controller for the 4-port Benes fabric. Accepts a permutation,
// validates it, quiesces and drains the fabric, loads the new switch state,
// waits SETTLE_CYCLES and reports done, or reports err with a code.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : benes_4_cfg_ctrl_if.slave (request handshake, fabric control/status)
// -----------------------------------------------------------------------------
module benes_4_cfg_ctrl
  import benes_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int DRAIN_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  benes_4_cfg_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e            r_state;
  logic [PERM_W-1:0] r_req_perm;
  logic [PERM_W-1:0] r_active_perm;
  logic [SW_W-1:0]   r_sw_state;
  logic              r_cfg_live;
  logic              r_quiesce;
  logic              r_done;
  logic              r_err;
  logic [ERR_W-1:0]  r_err_code;
  logic [CNT_W-1:0]  r_cnt;

  logic [SW_W-1:0]   w_lut_sw;
  logic              w_perm_ok;
  logic [CNT_W-1:0]  w_cnt_inc;

  benes_4_route_lut u_lut (
    .i_perm     (r_req_perm),
    .o_sw_state (w_lut_sw),
    .o_perm_ok  (w_perm_ok)
  );

  // Shared settle/drain counter saturates instead of wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_req_perm    <= PERM_IDENTITY;
      r_active_perm <= PERM_IDENTITY;
      r_sw_state    <= SW_IDENTITY;
      r_cfg_live    <= 1'b1;
      r_quiesce     <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_cnt         <= '0;
    end else begin
      // done/err are single-cycle pulses; only the branch that fires raises one.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_req_perm <= bus.req_perm;
            r_err_code <= ERR_NONE;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (!w_perm_ok) begin
            r_err      <= 1'b1;
            r_err_code <= ERR_PERM;
            r_state    <= IDLE;
          end else if (r_req_perm == r_active_perm) begin
            // Already configured: nothing to drain, acknowledge directly.
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_quiesce <= 1'b1;
            r_cnt     <= '0;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.net_busy) begin
            r_sw_state    <= w_lut_sw;
            r_active_perm <= r_req_perm;
            r_cfg_live    <= 1'b0;
            r_cnt         <= '0;
            r_state       <= SETTLE;
          end else if (r_cnt >= DRAIN_LAST) begin
            // This busy cycle is the DRAIN_TIMEOUT-th: abort, keep old config.
            r_cnt      <= w_cnt_inc;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_quiesce  <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        SETTLE: begin
          if (r_cnt >= SETTLE_LAST) begin
            r_cfg_live <= 1'b1;
            r_quiesce  <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.quiesce   = r_quiesce;
  assign bus.sw_state  = r_sw_state;
  assign bus.cfg_live  = r_cfg_live;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;

endmodule

// File: doc/benes_4_cfg_ctrl.md
Name: benes_4_cfg_ctrl

Overview:
Reconfiguration controller for the 4-port Benes switch fabric. It accepts permutation requests over a valid/ready handshake and checks each one is a true permutation. It then quiesces and drains the fabric, loads the six 2x2 switch-state bits, waits a settle period, and reports done or error. It sits between the fabric-management logic and the Benes switch fabric.

Parameters:
SETTLE_CYCLES, 2, cycles the fabric is held quiesced after a new switch state is loaded (legal range 1..2^CNT_W-1)
DRAIN_TIMEOUT, 255, max cycles in DRAIN with net_busy=1 before the request aborts (legal range 1..2^CNT_W-1)
CNT_W, 8, width of the shared settle/drain counter

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  permutation request valid
req_perm  in  8  {in0,in1,in2,in3}, 2 bits each; in0 is bits [7:6]
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
net_busy  in  1  fabric has traffic in flight
quiesce  out  1  upstream must stop injecting traffic while this is high
sw_state  out  6  {s0_0,s0_1,s0_2,s1_0,s1_1,s1_2}; s0_0 is bit 5
cfg_live  out  1  sw_state is settled and valid for traffic
done  out  1  one-cycle pulse: request completed successfully
err  out  1  one-cycle pulse: request rejected or aborted
err_code  out  2  0 = none, 1 = not a permutation, 2 = drain timeout; held until the next accept

Behaviour:
- Reset values:
  - state IDLE, sw_state=6'b111111 (identity), active_perm=8'h1B
  - cfg_live=1, quiesce=0, done=0, err=0, err_code=0
  - counter=0, req_ready=1
- Reset mid-operation: the request is abandoned and quiesce drops. No done or err pulse. Identity config is restored.
- States: IDLE, CHECK, DRAIN, SETTLE.
- IDLE:
  - req_ready=1.
  - On accept (cycle T): latch req_perm, clear err_code, go to CHECK.
- CHECK (T+1): a request is valid iff its four 2-bit fields are pairwise distinct.
  - Invalid: err=1 and err_code=1 at T+2, back to IDLE. sw_state and cfg_live are unchanged.
  - Valid and equal to active_perm: done=1 at T+2, back to IDLE. No quiesce is asserted.
  - Otherwise: quiesce=1 from T+2, counter=0, go to DRAIN.
- DRAIN:
  - If net_busy=0: load sw_state from the route lookup, load active_perm, drop cfg_live, counter=0, go to SETTLE. The earliest new sw_state is visible at T+3.
  - If net_busy=1: counter increments each cycle. When the counter reaches DRAIN_TIMEOUT, pulse err with err_code=2, drop quiesce, return to IDLE. The old config and cfg_live=1 are kept.
- SETTLE:
  - counter increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE: cfg_live=1, quiesce=0, done=1, return to IDLE.
  - With net_busy=0 throughout, done appears at T+3+SETTLE_CYCLES.
- net_busy is ignored outside DRAIN.
- req_valid while not in IDLE stalls the requester; nothing is dropped or queued.
- done and err are never high in the same cycle.
- All outputs are registered except req_ready, which decodes state==IDLE.
- The counter saturates and never wraps.
- Route lookup (combinational, in the sub-module), 8-bit perm → 6 bits:
  - 8'h1B → 111111
  - 8'h1E → 111110
  - 8'h27 → 111000
  - 8'hE4 → 100100
  - 8'h4B → 110111
  - the remaining permutations are defined in the fabric switch-setting table
  - non-permutations → 000000, never loaded because CHECK rejects them first

Decomposition:
- Shared package benes_pkg holds:
  - the state enum {IDLE, CHECK, DRAIN, SETTLE}
  - ERR_NONE/ERR_PERM/ERR_TIMEOUT constants
  - PERM_IDENTITY=8'h1B and SW_IDENTITY=6'b111111
  - port field widths
- One sub-module, benes_4_route_lut: a combinational perm → sw_state table plus a perm_ok flag. The controller instantiates it on the latched perm.

Test Plan:
1. Reset, then req_perm=8'h1E with net_busy=0 → quiesce=1 at T+2, sw_state=111110 at T+3, cfg_live=0 at T+3..T+4, done and cfg_live=1 at T+5.
2. req_perm=8'h0B (duplicate 0) → err=1 and err_code=1 at T+2; sw_state stays 111111; quiesce never asserted.
3. Identity 8'h1B right after reset → done at T+2, no quiesce; then 8'hE4 → sw_state=100100 and done at T+5.
4. 8'h27 with net_busy=1 held 10 cycles then released → sw_state=111000 in the cycle after release; done SETTLE_CYCLES later; no err.
5. DRAIN_TIMEOUT=4 with net_busy stuck at 1 → err with err_code=2, quiesce drops, sw_state and cfg_live unchanged, req_ready=1 again.
6. Assert rst during SETTLE after 8'h4B → next cycle: IDLE, sw_state=111111, cfg_live=1, quiesce=0, no done or err pulse.
